// File: rtl/gpad_scanner.sv
// Genesis 3/6-button joypad scanner: drives TH, runs 8-phase scans, decodes buttons.
// Optional GPAD_DEBOUNCE_EN: outputs change only after two matching consecutive scans.
module gpad_scanner #(
    parameter int unsigned PHASE_CYC = 500,
    parameter int unsigned GAP_CYC   = 100000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [5:0] PAD_IN,
    output logic       PAD_TH,
    output logic       P_UP,
    output logic       P_DOWN,
    output logic       P_LEFT,
    output logic       P_RIGHT,
    output logic       P_A,
    output logic       P_B,
    output logic       P_C,
    output logic       P_START,
    output logic       P_MODE,
    output logic       P_X,
    output logic       P_Y,
    output logic       P_Z,
    output logic       SIX_BTN,
    output logic       CONNECTED,
    output logic       VALID
);

    localparam int unsigned TMR_W = 20;
    localparam int unsigned VEC_W = 14;

    typedef enum logic [3:0] {
        ST_GAP, ST_PH0, ST_PH1, ST_PH2, ST_PH3,
        ST_PH4, ST_PH5, ST_PH6, ST_PH7, ST_COMMIT
    } state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   tmr;
    logic [TMR_W-1:0]   tmr_load_c;
    logic               tmr_done_c;
    logic               th_nxt_c;
    logic               commit_c;
    logic [5:0]         sync1, sync2;
    logic [5:0]         s_c;
    logic               present, six, smp_a, smp_b, smp_c, smp_start;
    logic [3:0]         dpad, ext;
    logic [VEC_W-1:0]   dec_c;
    logic [VEC_W-1:0]   out_vec;

    assign tmr_done_c = (tmr == '0);
    assign s_c        = ~sync2;
    assign commit_c   = (state == ST_PH7) && tmr_done_c;

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ST_GAP;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_GAP:    if (tmr_done_c) state_nxt = ST_PH0;
            ST_PH7:    if (tmr_done_c) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_GAP;
            ST_PH0, ST_PH1, ST_PH2, ST_PH3, ST_PH4, ST_PH5, ST_PH6:
                       if (tmr_done_c) state_nxt = state_t'(state + 4'd1);
            default:   state_nxt = ST_GAP;
        endcase
    end

    // Output logic: TH level and timer reload for the state being entered
    always_comb begin
        th_nxt_c   = 1'b1;
        tmr_load_c = '0;
        case (state_nxt)
            ST_PH0, ST_PH2, ST_PH4, ST_PH6: th_nxt_c = 1'b0;
            default:                        th_nxt_c = 1'b1;
        endcase
        case (state_nxt)
            ST_GAP:    tmr_load_c = TMR_W'(GAP_CYC - 1);
            ST_COMMIT: tmr_load_c = '0;
            default:   tmr_load_c = TMR_W'(PHASE_CYC - 1);
        endcase
    end

    // Shared down-counter; reloads on every state change
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                   tmr <= TMR_W'(GAP_CYC - 1);
        else if (state_nxt != state) tmr <= tmr_load_c;
        else if (!tmr_done_c)        tmr <= tmr - TMR_W'(1);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            PAD_TH <= 1'b1;
            sync1  <= 6'h3F;
            sync2  <= 6'h3F;
        end else begin
            PAD_TH <= th_nxt_c;
            sync1  <= PAD_IN;
            sync2  <= sync1;
        end
    end

    // Capture the synchronized pins on the last cycle of each phase
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            present   <= 1'b0;
            six       <= 1'b0;
            smp_a     <= 1'b0;
            smp_b     <= 1'b0;
            smp_c     <= 1'b0;
            smp_start <= 1'b0;
            dpad      <= '0;
            ext       <= '0;
        end else if (tmr_done_c) begin
            case (state)
                ST_PH0: begin
                    present   <= s_c[2] & s_c[3];
                    smp_a     <= s_c[4];
                    smp_start <= s_c[5];
                end
                ST_PH1: begin
                    dpad  <= s_c[3:0];
                    smp_b <= s_c[4];
                    smp_c <= s_c[5];
                end
                ST_PH4:  six <= &s_c[3:0];
                ST_PH5:  ext <= s_c[3:0];
                default: ;
            endcase
        end
    end

    // Decoded vector: {CONNECTED, SIX_BTN, U, D, L, R, A, B, C, START, MODE, X, Y, Z}
    always_comb begin
        dec_c = '0;
        if (present) begin
            dec_c = {1'b1, six, dpad[0], dpad[1], dpad[2], dpad[3],
                     smp_a, smp_b, smp_c, smp_start, six ? ext : 4'h0};
        end
    end

`ifdef GPAD_DEBOUNCE_EN
    logic [VEC_W-1:0] prev_vec;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_vec  <= '0;
            prev_vec <= '0;
            VALID    <= 1'b0;
        end else begin
            VALID <= commit_c;
            if (commit_c) begin
                prev_vec <= dec_c;
                if (dec_c == prev_vec) out_vec <= dec_c;
            end
        end
    end
`else
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_vec <= '0;
            VALID   <= 1'b0;
        end else begin
            VALID <= commit_c;
            if (commit_c) out_vec <= dec_c;
        end
    end
`endif

    assign {CONNECTED, SIX_BTN, P_UP, P_DOWN, P_LEFT, P_RIGHT,
            P_A, P_B, P_C, P_START, P_MODE, P_X, P_Y, P_Z} = out_vec;

endmodule
